fb_rect_writer: RTL

Drawing engine that drives the write port of the 160x120, 9-bit-colour framebuffer. It accepts one rectangle-fill command per handshake and rasterises it row-major, one pixel per clock. It presents WAx/WAy/dt/SW with the encoding the framebuffer write port expects. It sits between the CPU/IO command decode and the framebuffer; clear-screen is a full-area fill.

---
 rtl/fb_rect_writer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fb_rect_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rect_writer
//  Description : Rectangle-fill drawing engine for the 160x120, 9-bit colour
//                framebuffer write port. Accepts one fill command per
//                handshake, clamps it to the screen and rasterises it
//                row-major at one pixel per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_rect_writer #(
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int COLOR_W = 9
) (
    input  logic               clk50,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         x0,
    input  logic [7:0]         y0,
    input  logic [7:0]         x1,
    input  logic [7:0]         y1,
    input  logic [COLOR_W-1:0] color,
    output logic [9:0]         WAx,
    output logic [9:0]         WAy,
    output logic [COLOR_W-1:0] dt,
    output logic               SW,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] C_X_MAX = 8'(FB_W - 1);
    localparam logic [7:0] C_Y_MAX = 8'(FB_H - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    // Latched command: left edge and clamped right/bottom edges
    logic [7:0]         r_x0;
    logic [7:0]         r_cx1;
    logic [7:0]         r_cy1;

    // Registered write-port outputs
    logic [7:0]         r_wax;
    logic [7:0]         r_way;
    logic [COLOR_W-1:0] r_dt;
    logic               r_sw;
    logic               r_done;

    logic [7:0]         w_wax_nxt;
    logic [7:0]         w_way_nxt;
    logic [COLOR_W-1:0] w_dt_nxt;
    logic               w_sw_nxt;
    logic               w_done_nxt;

    logic [7:0]         w_cx1;
    logic [7:0]         w_cy1;
    logic               w_accept;
    logic               w_empty;
    logic               w_x_more;
    logic               w_y_more;

    // Clamping the far corner to the screen keeps the 8-bit counters from
    // ever stepping past the last valid pixel, so no wrap is possible.
    assign w_cx1    = (x1 > C_X_MAX) ? C_X_MAX : x1;
    assign w_cy1    = (y1 > C_Y_MAX) ? C_Y_MAX : y1;
    assign w_empty  = (x0 > w_cx1) || (y0 > w_cy1);
    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_x_more = (r_wax < r_cx1);
    assign w_y_more = (r_way < r_cy1);

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign WAx       = {2'b00, r_wax};
    assign WAy       = {2'b00, r_way};
    assign dt        = r_dt;
    assign SW        = r_sw;
    assign done      = r_done;

    // State register
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: empty commands skip straight to the one-cycle DONE state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = w_empty ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (!w_x_more && !w_y_more) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output next-values: raster walk, row-major, address held when idle
    always_comb begin
        w_wax_nxt  = r_wax;
        w_way_nxt  = r_way;
        w_dt_nxt   = r_dt;
        w_sw_nxt   = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_empty) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_wax_nxt = x0;
                        w_way_nxt = y0;
                        w_dt_nxt  = color;
                        w_sw_nxt  = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                if (w_x_more) begin
                    w_wax_nxt = r_wax + 8'd1;
                    w_sw_nxt  = 1'b1;
                end else if (w_y_more) begin
                    w_wax_nxt = r_x0;
                    w_way_nxt = r_way + 8'd1;
                    w_sw_nxt  = 1'b1;
                end else begin
                    w_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset drops any write in flight with no done pulse
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_wax  <= 8'd0;
            r_way  <= 8'd0;
            r_dt   <= '0;
            r_sw   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_wax  <= w_wax_nxt;
            r_way  <= w_way_nxt;
            r_dt   <= w_dt_nxt;
            r_sw   <= w_sw_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Command capture; inputs are free to change once accepted
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_x0  <= 8'd0;
            r_cx1 <= 8'd0;
            r_cy1 <= 8'd0;
        end else if (w_accept) begin
            r_x0  <= x0;
            r_cx1 <= w_cx1;
            r_cy1 <= w_cy1;
        end
    end

endmodule
`default_nettype wire
